// File: rtl/fp32_pkg.sv
// Shared FP32 field widths, operand classes, flag bit positions and integer limits
// for the FP32 decode path.
package fp32_pkg;

    localparam int EXP_IEEE754 = 8;
    localparam int MTS_IEEE754 = 23;
    localparam int EXP_BIAS    = 127;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_class_e;

    localparam int FLAG_INEXACT  = 0;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_INVALID  = 2;

    localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;

    typedef struct packed {
        logic                  sign;
        logic [MTS_IEEE754:0]  mant;
        logic signed [8:0]     exp_unb;
        fp_class_e             cls;
    } unpacked_t;

endpackage

// File: rtl/fp32_unpack.sv
// Combinational FP32 unpack: splits the fields, restores the hidden bit,
// removes the exponent bias and classifies the operand.
module fp32_unpack
    import fp32_pkg::*;
(
    input  logic [31:0]          fp_in,
    output logic                 sign,
    output logic [MTS_IEEE754:0] mant,
    output logic signed [8:0]    exp_unb,
    output fp_class_e            cls
);

    logic [EXP_IEEE754-1:0] exp_field;
    logic [MTS_IEEE754-1:0] mts_field;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
        exp_field = fp_in[30:23];
        mts_field = fp_in[22:0];
        sign      = fp_in[31];
        mant      = {1'b1, mts_field};
        exp_unb   = $signed({1'b0, exp_field}) - 9'sd127;
        cls       = NORMAL;
        // Denormals are folded into ZERO; they are far below 1.0 anyway.
        if (exp_field == '0) begin
            cls = ZERO;
        end else if (exp_field == '1) begin
            cls = (mts_field != '0) ? NAN : INF;
        end
    end

endmodule

// File: rtl/fp32_to_int32_conv.sv
// Two-stage valid/ready FP32 -> signed INT32 converter (unpack, then shift/sign/saturate).
// Define ROUND_NEAREST_EN for round-to-nearest-even; default is truncation toward zero.
module fp32_to_int32_conv
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_flags
);

    logic                 u_sign;
    logic [MTS_IEEE754:0] u_mant;
    logic signed [8:0]    u_exp;
    fp_class_e            u_cls;

    unpacked_t   s1_q, s1_d;
    logic        s1_valid_q, s1_valid_d;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [2:0]  out_flags_q, out_flags_d;
    logic        s2_advance;

    logic [4:0]  sh;
    logic [47:0] ext;
    logic [32:0] mag;
    logic [23:0] frac;
    logic        ovf, inv, inx;
    logic [31:0] conv_data;
    logic [2:0]  conv_flags;

    fp32_unpack u_unpack (
        .fp_in   (in_data),
        .sign    (u_sign),
        .mant    (u_mant),
        .exp_unb (u_exp),
        .cls     (u_cls)
    );

    // Stage 2 datapath: frac collects the dropped bits, guard bit at frac[23].
    always_comb begin
        sh        = '0;
        ext       = '0;
        mag       = '0;
        frac      = '0;
        ovf       = 1'b0;
        inv       = 1'b0;
        inx       = 1'b0;
        conv_data = '0;
        unique case (s1_q.cls)
            ZERO:   inx = |s1_q.mant[MTS_IEEE754-1:0];
            NAN:    inv = 1'b1;
            INF:    ovf = 1'b1;
            NORMAL: begin
                if (s1_q.exp_unb > 9'sd31) begin
                    ovf = 1'b1;
                end else if (s1_q.exp_unb >= 9'sd23) begin
                    sh  = 5'(s1_q.exp_unb - 9'sd23);
                    mag = {9'b0, s1_q.mant} << sh;
                end else if (s1_q.exp_unb >= -9'sd1) begin
                    sh   = 5'(9'sd23 - s1_q.exp_unb);
                    ext  = {s1_q.mant, 24'b0} >> sh;
                    mag  = {9'b0, ext[47:24]};
                    frac = ext[23:0];
                end else begin
                    frac = 24'd1;
                end
`ifdef ROUND_NEAREST_EN
                if (frac[23] && ((|frac[22:0]) || mag[0])) begin
                    mag = mag + 33'd1;
                end
`endif
                inx = |frac;
                // Negative side reaches one further: -2^31 is representable.
                if (!ovf && (mag > ({1'b0, INT32_MAX} + 33'(s1_q.sign)))) begin
                    ovf = 1'b1;
                end
                if (!ovf) begin
                    conv_data = s1_q.sign ? (~mag[31:0] + 32'd1) : mag[31:0];
                end
            end
            default: ;
        endcase
        if (inv) begin
            conv_data = INT32_MAX;
        end else if (ovf) begin
            conv_data = s1_q.sign ? INT32_MIN : INT32_MAX;
            inx       = 1'b0;
        end
        conv_flags                = '0;
        conv_flags[FLAG_INEXACT]  = inx;
        conv_flags[FLAG_OVERFLOW] = ovf;
        conv_flags[FLAG_INVALID]  = inv;
    end

    always_comb begin
        s2_advance  = ~s2_valid_q | out_ready;
        in_ready    = ~s1_valid_q | s2_advance;
        s1_valid_d  = s1_valid_q;
        s1_d        = s1_q;
        s2_valid_d  = s2_valid_q;
        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d = '{sign: u_sign, mant: u_mant, exp_unb: u_exp, cls: u_cls};
            end
        end
        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d  = conv_data;
                out_flags_d = conv_flags;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            s2_valid_q  <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            s2_valid_q  <= s2_valid_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp32_to_int32_conv.sv
// Self-checking bench for fp32_to_int32_conv: directed vectors, stall/reset scenarios
// and randomized operands scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_fp32_to_int32_conv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_flags;

    int total = 0;
    int bad   = 0;
    int n_out = 0;
    logic [34:0] exp_q[$];
    logic        held_v = 1'b0;
    logic [31:0] held_data;
    logic [2:0]  held_flags;
    logic        saw_block = 1'b0;
    logic        rand_mode = 1'b0;

    always #5 clk = ~clk;

    fp32_to_int32_conv dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: value = 1.mts * 2^e evaluated with integer arithmetic, then clamped.
    function automatic logic [34:0] ref_conv(input logic [31:0] f);
        int ex, e, sh;
        longint mant, ip, rem, half, v;
        logic inx;
        logic [31:0] sat;
        sat = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        ex  = int'(f[30:23]);
        if (ex == 0) return {2'b00, (f[22:0] != 0), 32'h0};
        if (ex == 255) begin
            if (f[22:0] != 0) return {3'b100, 32'h7FFF_FFFF};
            return {3'b010, sat};
        end
        e    = ex - 127;
        mant = longint'({1'b1, f[22:0]});
        inx  = 1'b0;
        if (e > 31) return {3'b010, sat};
        if (e >= 23) begin
            ip = mant << (e - 23);
        end else begin
            sh = 23 - e;
            if (sh > 24) begin
                ip  = 0;
                inx = 1'b1;
            end else begin
                ip   = mant >> sh;
                rem  = mant - (ip << sh);
                half = longint'(1) << (sh - 1);
                inx  = (rem != 0);
`ifdef ROUND_NEAREST_EN
                if (rem > half || (rem == half && ip[0])) ip++;
`endif
            end
        end
        v = f[31] ? -ip : ip;
        if (v > 64'sd2147483647 || v < -64'sd2147483648) return {3'b010, sat};
        return {2'b00, inx, v[31:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  ex;
        logic [31:0] m;
        case ($urandom_range(0, 9))
            0:       ex = 8'($urandom_range(0, 255));
            1:       ex = ($urandom_range(0, 1) != 0) ? 8'd0 : 8'd255;
            default: ex = 8'($urandom_range(110, 160));
        endcase
        m = $urandom;
        if ($urandom_range(0, 3) == 0) m = m & 32'h007F_0000;
        if ($urandom_range(0, 15) == 0) m = 32'h0;
        return {1'($urandom_range(0, 1)), ex, m[22:0]};
    endfunction

    // Holds in_valid until accepted (in_ready sampled mid-cycle), then queues the expectation.
    task automatic send(input logic [31:0] d, input logic [34:0] want);
        logic acc;
        int   cnt;
        in_valid = 1'b1;
        in_data  = d;
        cnt      = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            if (acc) exp_q.push_back(want);
            @(posedge clk);
            #1;
            cnt++;
        end while (!acc && cnt < 200);
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [31:0] d);
        send(d, ref_conv(d));
    endtask

    task automatic wait_drain();
        int cnt = 0;
        while (exp_q.size() != 0 && cnt < 300) begin
            @(posedge clk);
            cnt++;
        end
        #1;
        check("drain_empty", 64'(exp_q.size()), 0);
    endtask

    always @(negedge clk) begin
        logic [34:0] w;
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, held_data);
                check("stall_flags", out_flags, held_flags);
            end
            held_v     = out_valid && !out_ready;
            held_data  = out_data;
            held_flags = out_flags;
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("out_data", out_data, w[31:0]);
                    check("out_flags", out_flags, w[34:32]);
                    n_out++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int base;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_flags", out_flags, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Latency: accepted on the first edge, visible after the second.
        send(32'h4049_0FDB, {3'b001, 32'h0000_0003});
        check("lat_edge1", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_edge2", out_valid, 1);
        wait_drain();

        send(32'hC2F6_0000, {3'b000, 32'hFFFF_FF85});
        send(32'h8000_0000, {3'b000, 32'h0000_0000});
        send(32'h3F00_0000, {3'b001, 32'h0000_0000});
        send(32'h4F00_0000, {3'b010, 32'h7FFF_FFFF});
        send(32'hCF00_0000, {3'b000, 32'h8000_0000});
        send(32'hFF80_0000, {3'b010, 32'h8000_0000});
        send(32'h7FC0_0000, {3'b100, 32'h7FFF_FFFF});
`ifdef ROUND_NEAREST_EN
        send(32'h4020_0000, {3'b001, 32'h0000_0002});
        send(32'h4060_0000, {3'b001, 32'h0000_0004});
        send(32'h3FC0_0000, {3'b001, 32'h0000_0002});
        send(32'h3F40_0000, {3'b001, 32'h0000_0001});
`else
        send(32'h4020_0000, {3'b001, 32'h0000_0002});
        send(32'h4060_0000, {3'b001, 32'h0000_0003});
        send(32'h3FC0_0000, {3'b001, 32'h0000_0001});
        send(32'h3F40_0000, {3'b001, 32'h0000_0000});
`endif
        wait_drain();

        // Back-to-back stream with out_ready low for three cycles.
        base      = n_out;
        saw_block = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_model(rand_fp());
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        check("stall_in_ready_drop", saw_block, 1);
        check("stall_count", 64'(n_out - base), 6);

        // Fill both stages, then reset asynchronously mid-cycle.
        out_ready = 1'b0;
        send_model(32'h42F6_0000);
        send_model(32'h4049_0FDB);
        check("full_out_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_flags", out_flags, 0);
        exp_q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        check("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(32'hC2F6_0000, {3'b000, 32'hFFFF_FF85});
        check("post_rst_lat1", out_valid, 0);
        @(posedge clk);
        #1;
        check("post_rst_lat2", out_valid, 1);
        wait_drain();

        // Randomized operands, idle gaps and backpressure.
        base      = n_out;
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            send_model(rand_fp());
        end
        rand_mode = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        wait_drain();
        check("rand_count", 64'(n_out - base), 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
